// File: rtl/ram_arbiter.sv
// Arbitrates the CPU fetch port and load/store port onto the single MMU request
// channel, with fixed or round-robin tie-break, abortable fetches and a bus watchdog.
module ram_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SEL_W     = DATA_W / 8,
   parameter int DATA_PRIO = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   output logic              if_tlb_err_o,
   output logic              if_bus_err_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [SEL_W-1:0]  d_sel_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              d_tlb_err_o,
   output logic              d_tlb_mod_o,
   output logic              d_bus_err_o,
   output logic              m_ce_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   output logic [SEL_W-1:0]  m_sel_o,
   input  logic              m_ready_i,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_tlb_err_i,
   input  logic              m_mod_i
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rr_data_q, rr_data_d;   // 1: data wins the next tie
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              if_tlb_err_q, if_tlb_err_d;
   logic              if_bus_err_q, if_bus_err_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              d_ready_q, d_ready_d;
   logic              d_tlb_err_q, d_tlb_err_d;
   logic              d_tlb_mod_q, d_tlb_mod_d;
   logic              d_bus_err_q, d_bus_err_d;
   logic              m_ce_q, m_ce_d;
   logic              m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [SEL_W-1:0]  m_sel_q, m_sel_d;

   logic tie, pick_d, wd_hit;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rr_data_q    <= 1'b1;
         if_rdata_q   <= '0;
         if_ready_q   <= 1'b0;
         if_tlb_err_q <= 1'b0;
         if_bus_err_q <= 1'b0;
         d_rdata_q    <= '0;
         d_ready_q    <= 1'b0;
         d_tlb_err_q  <= 1'b0;
         d_tlb_mod_q  <= 1'b0;
         d_bus_err_q  <= 1'b0;
         m_ce_q       <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_sel_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_data_q    <= rr_data_d;
         if_rdata_q   <= if_rdata_d;
         if_ready_q   <= if_ready_d;
         if_tlb_err_q <= if_tlb_err_d;
         if_bus_err_q <= if_bus_err_d;
         d_rdata_q    <= d_rdata_d;
         d_ready_q    <= d_ready_d;
         d_tlb_err_q  <= d_tlb_err_d;
         d_tlb_mod_q  <= d_tlb_mod_d;
         d_bus_err_q  <= d_bus_err_d;
         m_ce_q       <= m_ce_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_sel_q      <= m_sel_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rr_data_d    = rr_data_q;
      if_rdata_d   = if_rdata_q;
      if_ready_d   = if_ready_q;
      if_tlb_err_d = if_tlb_err_q;
      if_bus_err_d = if_bus_err_q;
      d_rdata_d    = d_rdata_q;
      d_ready_d    = d_ready_q;
      d_tlb_err_d  = d_tlb_err_q;
      d_tlb_mod_d  = d_tlb_mod_q;
      d_bus_err_d  = d_bus_err_q;
      m_ce_d       = m_ce_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_sel_d      = m_sel_q;
      tie          = if_req_i && d_req_i;
      pick_d       = d_req_i && (!if_req_i || (DATA_PRIO != 0) || rr_data_q);
      wd_hit       = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

      case (state_q)
         IDLE: begin
            if (tie && (DATA_PRIO == 0)) rr_data_d = !pick_d;
            if (pick_d) begin
               m_ce_d    = 1'b1;
               m_we_d    = d_we_i;
               m_addr_d  = d_addr_i;
               m_wdata_d = d_wdata_i;
               m_sel_d   = d_sel_i;
               cnt_d     = '0;
               state_d   = D_ACC;
            end else if (if_req_i) begin
               m_ce_d    = 1'b1;
               m_we_d    = 1'b0;
               m_addr_d  = if_addr_i;
               m_wdata_d = '0;
               m_sel_d   = '1;
               cnt_d     = '0;
               state_d   = IF_ACC;
            end
         end
         IF_ACC: begin
            // Completion beats abort; a withdrawn fetch beats the watchdog.
            if (m_ready_i) begin
               m_ce_d       = 1'b0;
               if_ready_d   = 1'b1;
               if_rdata_d   = m_rdata_i;
               if_tlb_err_d = m_tlb_err_i;
               if_bus_err_d = 1'b0;
               state_d      = RESP;
            end else if (!if_req_i || (if_addr_i != m_addr_q)) begin
               m_ce_d  = 1'b0;
               state_d = IDLE;
            end else if (wd_hit) begin
               m_ce_d       = 1'b0;
               if_ready_d   = 1'b1;
               if_rdata_d   = '0;
               if_tlb_err_d = 1'b0;
               if_bus_err_d = 1'b1;
               state_d      = RESP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         D_ACC: begin
            if (m_ready_i) begin
               m_ce_d      = 1'b0;
               d_ready_d   = 1'b1;
               d_rdata_d   = m_we_q ? '0 : m_rdata_i;
               d_tlb_err_d = m_tlb_err_i;
               d_tlb_mod_d = m_we_q && m_mod_i;
               d_bus_err_d = 1'b0;
               state_d     = RESP;
            end else if (wd_hit) begin
               m_ce_d      = 1'b0;
               d_ready_d   = 1'b1;
               d_rdata_d   = '0;
               d_tlb_err_d = 1'b0;
               d_tlb_mod_d = 1'b0;
               d_bus_err_d = 1'b1;
               state_d     = RESP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if_ready_d   = 1'b0;
            if_tlb_err_d = 1'b0;
            if_bus_err_d = 1'b0;
            d_ready_d    = 1'b0;
            d_tlb_err_d  = 1'b0;
            d_tlb_mod_d  = 1'b0;
            d_bus_err_d  = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign if_rdata_o   = if_rdata_q;
   assign if_ready_o   = if_ready_q;
   assign if_tlb_err_o = if_tlb_err_q;
   assign if_bus_err_o = if_bus_err_q;
   assign d_rdata_o    = d_rdata_q;
   assign d_ready_o    = d_ready_q;
   assign d_tlb_err_o  = d_tlb_err_q;
   assign d_tlb_mod_o  = d_tlb_mod_q;
   assign d_bus_err_o  = d_bus_err_q;
   assign m_ce_o       = m_ce_q;
   assign m_we_o       = m_we_q;
   assign m_addr_o     = m_addr_q;
   assign m_wdata_o    = m_wdata_q;
   assign m_sel_o      = m_sel_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: unit 0 uses data priority with a 4-cycle watchdog,
// unit 1 uses round-robin with the watchdog disabled.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req [2];
   logic [31:0] if_addr [2];
   logic [31:0] if_rdata [2];
   logic        if_ready [2], if_tlb_err [2], if_bus_err [2];
   logic        d_req [2], d_we [2];
   logic [3:0]  d_sel [2];
   logic [31:0] d_addr [2], d_wdata [2], d_rdata [2];
   logic        d_ready [2], d_tlb_err [2], d_tlb_mod [2], d_bus_err [2];
   logic        m_ce [2], m_we [2];
   logic [31:0] m_addr [2], m_wdata [2];
   logic [3:0]  m_sel [2];
   logic        m_ready [2];
   logic [31:0] m_rdata [2];
   logic        m_tlb_err [2], m_mod [2];

   int   n_vec = 0;
   int   n_err = 0;
   logic rr_fav_d [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ram_arbiter #(
         .ADDR_W(32), .DATA_W(32), .SEL_W(4),
         .DATA_PRIO((g == 0) ? 1 : 0),
         .TIMEOUT((g == 0) ? 4 : 0)
      ) u_dut (
         .clk_i(clk), .rst_ni(rst_n),
         .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_rdata_o(if_rdata[g]),
         .if_ready_o(if_ready[g]), .if_tlb_err_o(if_tlb_err[g]), .if_bus_err_o(if_bus_err[g]),
         .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_sel_i(d_sel[g]), .d_addr_i(d_addr[g]),
         .d_wdata_i(d_wdata[g]), .d_rdata_o(d_rdata[g]), .d_ready_o(d_ready[g]),
         .d_tlb_err_o(d_tlb_err[g]), .d_tlb_mod_o(d_tlb_mod[g]), .d_bus_err_o(d_bus_err[g]),
         .m_ce_o(m_ce[g]), .m_we_o(m_we[g]), .m_addr_o(m_addr[g]), .m_wdata_o(m_wdata[g]),
         .m_sel_o(m_sel[g]), .m_ready_i(m_ready[g]), .m_rdata_i(m_rdata[g]),
         .m_tlb_err_i(m_tlb_err[g]), .m_mod_i(m_mod[g])
      );
   end

   function automatic logic prio(input int u);
      return (u == 0);
   endfunction

   function automatic int tmo(input int u);
      return (u == 0) ? 4 : 0;
   endfunction

   function automatic logic [140:0] outs(input int u);
      return {if_rdata[u], if_ready[u], if_tlb_err[u], if_bus_err[u], d_rdata[u], d_ready[u],
              d_tlb_err[u], d_tlb_mod[u], d_bus_err[u], m_ce[u], m_we[u], m_addr[u],
              m_wdata[u], m_sel[u]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs(input int u);
      if_req[u] = 0; if_addr[u] = '0; d_req[u] = 0; d_we[u] = 0; d_sel[u] = '0;
      d_addr[u] = '0; d_wdata[u] = '0; m_ready[u] = 0; m_rdata[u] = '0;
      m_tlb_err[u] = 0; m_mod[u] = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs(0); idle_inputs(1);
      if_req[0] = 1; d_req[1] = 1;
      repeat (3) tick();
      for (int u = 0; u < 2; u++) begin
         n_vec++;
         if (outs(u) !== '0) begin
            n_err++; $display("FAIL reset_outs u%0d: got %h want 0", u, outs(u));
         end
      end
      idle_inputs(0); idle_inputs(1);
      rst_n = 1;
      rr_fav_d[0] = 1; rr_fav_d[1] = 1;
      tick();
   endtask

   task automatic test_single_fetch();
      if_req[0] = 1; if_addr[0] = 32'h8000_0000;
      tick();
      n_vec++;
      if ({m_ce[0], m_we[0], m_addr[0], m_sel[0], if_ready[0]} !== {2'b10, 32'h8000_0000, 4'hF, 1'b0}) begin
         n_err++; $display("FAIL fetch_req: got %b %b %h %h %b want 1 0 80000000 f 0",
                           m_ce[0], m_we[0], m_addr[0], m_sel[0], if_ready[0]);
      end
      m_ready[0] = 1; m_rdata[0] = 32'h3C01_1234; m_tlb_err[0] = 0;
      tick();
      m_ready[0] = 0; if_req[0] = 0;
      n_vec++;
      if ({if_ready[0], if_rdata[0], if_tlb_err[0], if_bus_err[0], m_ce[0], d_ready[0]} !==
          {1'b1, 32'h3C01_1234, 4'b0000}) begin
         n_err++; $display("FAIL fetch_resp: got rdy=%b data=%h tlb=%b bus=%b ce=%b drdy=%b",
                           if_ready[0], if_rdata[0], if_tlb_err[0], if_bus_err[0], m_ce[0], d_ready[0]);
      end
      tick();
      n_vec++;
      if ({if_ready[0], m_ce[0]} !== 2'b00) begin
         n_err++; $display("FAIL fetch_pulse_len: got rdy=%b ce=%b want 0 0", if_ready[0], m_ce[0]);
      end
   endtask

   task automatic test_tie_prio();
      if_req[0] = 1; if_addr[0] = 32'h0000_4000;
      d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF; d_sel[0] = 4'b0011;
      tick();
      n_vec++;
      if ({m_ce[0], m_we[0], m_addr[0], m_wdata[0], m_sel[0]} !== {2'b11, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
         n_err++; $display("FAIL tie_data_grant: got ce=%b we=%b a=%h wd=%h sel=%b",
                           m_ce[0], m_we[0], m_addr[0], m_wdata[0], m_sel[0]);
      end
      m_ready[0] = 1; m_rdata[0] = 32'h1234_5678; m_mod[0] = 1; m_tlb_err[0] = 0;
      tick();
      m_ready[0] = 0; m_mod[0] = 0; d_req[0] = 0;
      n_vec++;
      if ({d_ready[0], d_rdata[0], d_tlb_mod[0], d_bus_err[0], if_ready[0], m_ce[0]} !== {1'b1, 32'h0, 4'b1000}) begin
         n_err++; $display("FAIL tie_write_resp: got rdy=%b rd=%h mod=%b bus=%b ifrdy=%b ce=%b",
                           d_ready[0], d_rdata[0], d_tlb_mod[0], d_bus_err[0], if_ready[0], m_ce[0]);
      end
      tick();
      n_vec++;
      if ({m_ce[0], d_ready[0], d_tlb_mod[0]} !== 3'b000) begin
         n_err++; $display("FAIL tie_dead_cycle: got ce=%b rdy=%b mod=%b want 000", m_ce[0], d_ready[0], d_tlb_mod[0]);
      end
      tick();
      n_vec++;
      if ({m_ce[0], m_we[0], m_addr[0], m_sel[0]} !== {2'b10, 32'h4000, 4'hF}) begin
         n_err++; $display("FAIL tie_fetch_next: got ce=%b we=%b a=%h sel=%h", m_ce[0], m_we[0], m_addr[0], m_sel[0]);
      end
      m_ready[0] = 1; m_rdata[0] = 32'hCAFE_F00D; m_tlb_err[0] = 1;
      tick();
      m_ready[0] = 0; m_tlb_err[0] = 0; if_req[0] = 0;
      n_vec++;
      if ({if_ready[0], if_rdata[0], if_tlb_err[0]} !== {1'b1, 32'hCAFE_F00D, 1'b1}) begin
         n_err++; $display("FAIL tie_fetch_resp: got rdy=%b rd=%h tlb=%b", if_ready[0], if_rdata[0], if_tlb_err[0]);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic exp_d;
      if_req[1] = 1; if_addr[1] = 32'hA0;
      d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'hD0; d_sel[1] = 4'hF;
      for (int i = 0; i < 4; i++) begin
         exp_d = (i % 2 == 0);
         tick();
         n_vec++;
         if ({m_ce[1], m_addr[1]} !== {1'b1, exp_d ? 32'hD0 : 32'hA0}) begin
            n_err++; $display("FAIL rr_grant_%0d: got ce=%b a=%h want data=%b", i, m_ce[1], m_addr[1], exp_d);
         end
         m_ready[1] = 1; m_rdata[1] = 32'(i + 1);
         tick();
         m_ready[1] = 0;
         n_vec++;
         if ({d_ready[1], if_ready[1]} !== {exp_d, !exp_d}) begin
            n_err++; $display("FAIL rr_ready_%0d: got d=%b if=%b want d=%b", i, d_ready[1], if_ready[1], exp_d);
         end
         tick();
      end
      if_req[1] = 0; d_req[1] = 0;
      rr_fav_d[1] = 1;
      tick();
   endtask

   task automatic test_abort();
      if_req[0] = 1; if_addr[0] = 32'h1000;
      tick();
      tick();
      n_vec++;
      if ({m_ce[0], m_addr[0]} !== {1'b1, 32'h1000}) begin
         n_err++; $display("FAIL abort_first: got ce=%b a=%h want 1 1000", m_ce[0], m_addr[0]);
      end
      if_addr[0] = 32'h2000;
      tick();
      n_vec++;
      if ({m_ce[0], if_ready[0]} !== 2'b00) begin
         n_err++; $display("FAIL abort_drop: got ce=%b rdy=%b want 0 0", m_ce[0], if_ready[0]);
      end
      tick();
      n_vec++;
      if ({m_ce[0], m_addr[0]} !== {1'b1, 32'h2000}) begin
         n_err++; $display("FAIL abort_restart: got ce=%b a=%h want 1 2000", m_ce[0], m_addr[0]);
      end
      m_ready[0] = 1; m_rdata[0] = 32'h2000_DA7A;
      tick();
      m_ready[0] = 0; if_req[0] = 0;
      n_vec++;
      if ({if_ready[0], if_rdata[0]} !== {1'b1, 32'h2000_DA7A}) begin
         n_err++; $display("FAIL abort_resp: got rdy=%b rd=%h", if_ready[0], if_rdata[0]);
      end
      tick();
      // completion on the same edge as an address change
      if_req[0] = 1; if_addr[0] = 32'h3000;
      tick();
      if_addr[0] = 32'h4000; m_ready[0] = 1; m_rdata[0] = 32'h3333_3333;
      tick();
      m_ready[0] = 0; if_req[0] = 0;
      n_vec++;
      if ({if_ready[0], if_rdata[0]} !== {1'b1, 32'h3333_3333}) begin
         n_err++; $display("FAIL abort_vs_done: got rdy=%b rd=%h want 1 33333333", if_ready[0], if_rdata[0]);
      end
      tick();
      tick();
      // withdrawal of if_req
      if_req[0] = 1; if_addr[0] = 32'h5000;
      tick();
      if_req[0] = 0;
      tick();
      tick();
      n_vec++;
      if ({m_ce[0], if_ready[0]} !== 2'b00) begin
         n_err++; $display("FAIL abort_req_drop: got ce=%b rdy=%b want 0 0", m_ce[0], if_ready[0]);
      end
   endtask

   task automatic test_timeout();
      int ce_cycles;
      logic got;
      d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h200; d_sel[0] = 4'hF;
      m_ready[0] = 0; m_rdata[0] = 32'hBAD0_BAD0;
      tick();
      ce_cycles = 0; got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (m_ce[0]) ce_cycles++;
         tick();
         if (d_ready[0]) got = 1;
      end
      d_req[0] = 0;
      n_vec++;
      if ({got, ce_cycles} !== {1'b1, 32'd4}) begin
         n_err++; $display("FAIL timeout_ce_len: got done=%b ce_cycles=%0d want 1 4", got, ce_cycles);
      end
      n_vec++;
      if ({d_ready[0], d_bus_err[0], d_rdata[0], d_tlb_err[0], m_ce[0]} !== {2'b11, 32'h0, 2'b00}) begin
         n_err++; $display("FAIL timeout_resp: got rdy=%b bus=%b rd=%h tlb=%b ce=%b",
                           d_ready[0], d_bus_err[0], d_rdata[0], d_tlb_err[0], m_ce[0]);
      end
      tick();
      n_vec++;
      if ({d_ready[0], d_bus_err[0]} !== 2'b00) begin
         n_err++; $display("FAIL timeout_clear: got rdy=%b bus=%b want 0 0", d_ready[0], d_bus_err[0]);
      end
      // watchdog disabled on unit 1: a long stall must not time out
      d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h204; d_sel[1] = 4'hF;
      tick();
      ce_cycles = 0;
      for (int k = 0; k < 20; k++) begin
         if (m_ce[1] && !d_ready[1]) ce_cycles++;
         tick();
      end
      n_vec++;
      if (ce_cycles !== 20) begin
         n_err++; $display("FAIL nowd_stall: got %0d stalled cycles want 20", ce_cycles);
      end
      m_ready[1] = 1; m_rdata[1] = 32'h0BAD_F00D;
      tick();
      m_ready[1] = 0; d_req[1] = 0;
      n_vec++;
      if ({d_ready[1], d_bus_err[1], d_rdata[1]} !== {2'b10, 32'h0BAD_F00D}) begin
         n_err++; $display("FAIL nowd_resp: got rdy=%b bus=%b rd=%h", d_ready[1], d_bus_err[1], d_rdata[1]);
      end
      tick();
   endtask

   task automatic test_async_reset();
      d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h300; d_wdata[0] = 32'h55AA; d_sel[0] = 4'b1100;
      tick();
      n_vec++;
      if (m_ce[0] !== 1'b1) begin
         n_err++; $display("FAIL areset_pre: got ce=%b want 1", m_ce[0]);
      end
      #3 rst_n = 0;
      #1;
      for (int u = 0; u < 2; u++) begin
         n_vec++;
         if (outs(u) !== '0) begin
            n_err++; $display("FAIL areset_immediate u%0d: got %h want 0", u, outs(u));
         end
      end
      d_req[0] = 0;
      @(posedge clk);
      #1 rst_n = 1;
      rr_fav_d[0] = 1; rr_fav_d[1] = 1;
      tick();
      n_vec++;
      if (outs(0) !== '0) begin
         n_err++; $display("FAIL areset_no_stale: got %h want 0", outs(0));
      end
      if_req[0] = 1; if_addr[0] = 32'h600;
      tick();
      n_vec++;
      if ({m_ce[0], m_addr[0]} !== {1'b1, 32'h600}) begin
         n_err++; $display("FAIL areset_restart: got ce=%b a=%h want 1 600", m_ce[0], m_addr[0]);
      end
      m_ready[0] = 1; m_rdata[0] = 32'h600D;
      tick();
      m_ready[0] = 0; if_req[0] = 0;
      n_vec++;
      if ({if_ready[0], if_rdata[0], d_ready[0]} !== {1'b1, 32'h600D, 1'b0}) begin
         n_err++; $display("FAIL areset_resp: got rdy=%b rd=%h drdy=%b", if_ready[0], if_rdata[0], d_ready[0]);
      end
      tick();
   endtask

   task automatic test_random(input int u, input int n);
      logic pend_if, pend_d, win_d, tie, to, tlb, mod;
      logic [31:0] rd;
      int lat, done_k;
      pend_if = 0; pend_d = 0;
      for (int t = 0; t < n; t++) begin
         if (!pend_if && $urandom_range(0, 1) == 1) begin
            pend_if = 1; if_req[u] = 1; if_addr[u] = $urandom;
         end
         if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_if)) begin
            pend_d = 1; d_req[u] = 1; d_we[u] = 1'($urandom_range(0, 1));
            d_addr[u] = $urandom; d_wdata[u] = $urandom; d_sel[u] = 4'($urandom_range(0, 15));
         end
         tie   = pend_if && pend_d;
         win_d = pend_d && (!pend_if || prio(u) || rr_fav_d[u]);
         if (tie && !prio(u)) rr_fav_d[u] = !win_d;
         tick();
         n_vec++;
         if (win_d) begin
            if ({m_ce[u], m_we[u], m_addr[u], m_sel[u], m_wdata[u]} !==
                {1'b1, d_we[u], d_addr[u], d_sel[u], d_wdata[u]}) begin
               n_err++; $display("FAIL rnd_dgrant u%0d t%0d: got ce=%b we=%b a=%h sel=%h wd=%h want a=%h",
                                 u, t, m_ce[u], m_we[u], m_addr[u], m_sel[u], m_wdata[u], d_addr[u]);
            end
         end else begin
            if ({m_ce[u], m_we[u], m_addr[u], m_sel[u]} !== {2'b10, if_addr[u], 4'hF}) begin
               n_err++; $display("FAIL rnd_igrant u%0d t%0d: got ce=%b we=%b a=%h sel=%h want a=%h",
                                 u, t, m_ce[u], m_we[u], m_addr[u], m_sel[u], if_addr[u]);
            end
         end
         lat = $urandom_range(0, (u == 0) ? 5 : 3);
         rd = $urandom; tlb = 1'($urandom_range(0, 1)); mod = 1'($urandom_range(0, 1));
         done_k = (tmo(u) > 0 && lat >= tmo(u)) ? tmo(u) - 1 : lat;
         to = (done_k != lat);
         for (int k = 0; k <= done_k; k++) begin
            m_ready[u]   = (k == lat);
            m_rdata[u]   = (k == lat) ? rd : $urandom;
            m_tlb_err[u] = (k == lat) ? tlb : 1'($urandom_range(0, 1));
            m_mod[u]     = (k == lat) ? mod : 1'($urandom_range(0, 1));
            if (win_d && k == 0 && $urandom_range(0, 3) == 0) d_req[u] = 0;
            tick();
            m_ready[u] = 0;
            if (k < done_k) begin
               n_vec++;
               if ({m_ce[u], if_ready[u], d_ready[u]} !== 3'b100) begin
                  n_err++; $display("FAIL rnd_wait u%0d t%0d k%0d: got ce=%b ir=%b dr=%b want 1 0 0",
                                    u, t, k, m_ce[u], if_ready[u], d_ready[u]);
               end
            end
         end
         n_vec++;
         if (win_d) begin
            if ({d_ready[u], if_ready[u], m_ce[u], d_rdata[u], d_tlb_err[u], d_tlb_mod[u], d_bus_err[u]} !==
                {3'b100, (to || d_we[u]) ? 32'h0 : rd, !to && tlb, !to && d_we[u] && mod, to}) begin
               n_err++; $display("FAIL rnd_dresp u%0d t%0d: got rdy=%b ir=%b ce=%b rd=%h tlb=%b mod=%b bus=%b (we=%b to=%b mrd=%h)",
                                 u, t, d_ready[u], if_ready[u], m_ce[u], d_rdata[u], d_tlb_err[u],
                                 d_tlb_mod[u], d_bus_err[u], d_we[u], to, rd);
            end
            pend_d = 0; d_req[u] = 0;
         end else begin
            if ({if_ready[u], d_ready[u], m_ce[u], if_rdata[u], if_tlb_err[u], if_bus_err[u]} !==
                {3'b100, to ? 32'h0 : rd, !to && tlb, to}) begin
               n_err++; $display("FAIL rnd_iresp u%0d t%0d: got rdy=%b dr=%b ce=%b rd=%h tlb=%b bus=%b (to=%b mrd=%h)",
                                 u, t, if_ready[u], d_ready[u], m_ce[u], if_rdata[u], if_tlb_err[u],
                                 if_bus_err[u], to, rd);
            end
            pend_if = 0; if_req[u] = 0;
         end
         tick();
         n_vec++;
         if ({m_ce[u], if_ready[u], d_ready[u], if_tlb_err[u], if_bus_err[u], d_tlb_err[u],
              d_tlb_mod[u], d_bus_err[u]} !== 8'h00) begin
            n_err++; $display("FAIL rnd_dead u%0d t%0d: got ce=%b ir=%b dr=%b flags=%b%b%b%b%b",
                              u, t, m_ce[u], if_ready[u], d_ready[u], if_tlb_err[u], if_bus_err[u],
                              d_tlb_err[u], d_tlb_mod[u], d_bus_err[u]);
         end
      end
      if_req[u] = 0; d_req[u] = 0;
      tick();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_fetch();
      test_tie_prio();
      test_round_robin();
      test_abort();
      test_timeout();
      test_async_reset();
      test_random(0, 40);
      test_random(1, 40);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Parametrised successor to the CPU-side RAM adapter. It arbitrates between the instruction-fetch port and the load/store port onto the single MMU request channel. It adds configurable data width, selectable priority (fixed or round-robin), abortable fetches and a bus-timeout watchdog. It sits between the CPU pipeline (PC/IF and MEM stages) and the MMU.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports; must be a multiple of 8
SEL_W, DATA_W/8, byte-select width
DATA_PRIO, 1, 1 = data port always wins a tie; 0 = round-robin tie-break (last loser wins)
TIMEOUT, 255, max cycles waiting for m_ready before error; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request, held until if_ready or abort
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word
if_ready  out  1  one-cycle fetch completion pulse
if_tlb_err  out  1  TLB error for the completed fetch
if_bus_err  out  1  fetch timed out (valid with if_ready)
d_req  in  1  load/store request, held until d_ready
d_we  in  1  1 = write, 0 = read
d_sel  in  SEL_W  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data; zero on a write
d_ready  out  1  one-cycle completion pulse
d_tlb_err  out  1  TLB error (valid with d_ready)
d_tlb_mod  out  1  TLB modify exception, writes only (valid with d_ready)
d_bus_err  out  1  data access timed out (valid with d_ready)
m_ce  out  1  MMU chip enable
m_we  out  1  MMU write enable
m_addr  out  ADDR_W  MMU address
m_wdata  out  DATA_W  MMU write data
m_sel  out  SEL_W  MMU byte enables; all ones for fetches
m_ready  in  1  MMU access complete
m_rdata  in  DATA_W  MMU read data
m_tlb_err  in  1  MMU TLB miss/invalid
m_mod  in  1  MMU TLB modify fault

Behaviour:
- All outputs are registered. On rst low, all outputs go to 0 immediately, the FSM goes to IDLE, the watchdog counter clears to 0 and the round-robin pointer resets to favour data. Any in-flight access is dropped without a ready pulse.
- FSM states: IDLE, IF_ACC, D_ACC, RESP.
- IDLE: at the edge, arbitrate the requests.
  - If only one request is high, grant it.
  - If both are high, DATA_PRIO=1 grants data. DATA_PRIO=0 grants the port that did not win the previous tie.
  - On grant: latch the request fields into the m_* outputs, set m_ce=1, clear the watchdog counter, and move to IF_ACC or D_ACC.
- *_ACC: m_ce and the m_* outputs stay stable. At each edge:
  - If m_ready=1: capture m_rdata, m_tlb_err and m_mod (m_mod for writes only), set m_ce=0, set the granted port's ready=1 (its other completion flags valid in the same cycle), move to RESP.
  - Otherwise, if TIMEOUT>0 and the counter equals TIMEOUT-1: set m_ce=0, set ready=1 with bus_err=1 and rdata=0, move to RESP.
  - Otherwise, increment the counter.
- Fetch abort: in IF_ACC, if if_req=0 or if_addr differs from the latched address (and m_ready=0): set m_ce=0 and go to IDLE with no if_ready. If m_ready=1 on that same edge, completion wins.
- Data accesses are never aborted. If d_req drops mid-access, the access still completes and d_ready still pulses.
- RESP: ready is high for exactly this one cycle. The next edge clears all ready and error flags and returns to IDLE. This gives one dead cycle between back-to-back accesses.
- Minimum latency: request seen at edge 0, m_ce high in cycle 1, m_ready=1 sampled at edge 1, ready high in cycle 2.
- Write completion drives d_rdata=0. A read completion drives d_tlb_mod=0.
- The watchdog counter is ceil(log2(TIMEOUT+1)) bits wide and never wraps; it is cleared on every grant.

Test Plan:
- Single fetch: if_req=1, if_addr=0x80000000; MMU returns m_ready=1 with m_rdata=0x3C011234 one cycle after m_ce -> m_sel=4'hF, m_we=0; if_ready pulses one cycle with if_rdata=0x3C011234, if_tlb_err=0.
- Tie, DATA_PRIO=1: if_req and d_req rise together, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_sel=4'b0011 -> data granted first (m_we=1, m_sel=0011), d_ready with d_rdata=0, then fetch granted after the RESP cycle.
- Round-robin, DATA_PRIO=0: both requests held continuously for 4 accesses -> grants alternate D, IF, D, IF.
- Fetch abort: if_addr changes 0x1000 -> 0x2000 while in IF_ACC with m_ready=0 -> m_ce drops, no if_ready, a new access at 0x2000 starts, if_ready carries the 0x2000 data.
- Timeout, TIMEOUT=4: d_req read with m_ready held 0 -> m_ce high 4 cycles, then d_ready=1, d_bus_err=1, d_rdata=0.
- Async reset: assert rst=0 mid-D_ACC between edges -> m_ce and all outputs 0 immediately; after release, the next request restarts cleanly with no stale ready.
